// File: rtl/hwmod_reset_ctrl.sv
// Core reset controller: stretches VRASED/CASU violation requests into a clean
// core reset, records sticky causes, counts events and supervises handler entry.
module hwmod_reset_ctrl #(
   parameter int          STRETCH_CYCLES = 16,
   parameter int          TIMEOUT_CYCLES = 64,
   parameter int          CNT_WIDTH      = 8,
   parameter logic [15:0] RESET_HANDLER  = 16'h0000
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 vrased_reset,
   input  logic                 casu_reset,
   input  logic [15:0]          pc,
   input  logic                 cause_clr,
   output logic                 core_reset,
   output logic [2:0]           cause,
   output logic [CNT_WIDTH-1:0] viol_count,
   output logic                 busy
);

   localparam int MAX_CYCLES = (STRETCH_CYCLES > TIMEOUT_CYCLES) ? STRETCH_CYCLES : TIMEOUT_CYCLES;
   localparam int CTR_W      = (MAX_CYCLES > 2) ? $clog2(MAX_CYCLES) : 1;

   localparam logic [CTR_W-1:0]     STRETCH_LOAD = CTR_W'(STRETCH_CYCLES - 1);
   localparam logic [CTR_W-1:0]     TIMEOUT_LOAD = CTR_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CTR_W-1:0]     CTR_ONE      = CTR_W'(1);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX      = '1;
   localparam logic [CNT_WIDTH-1:0] CNT_ONE      = CNT_WIDTH'(1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HOLD = 2'd1,
      ST_WAIT = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [CTR_W-1:0]       ctr_q, ctr_d;
   logic                   core_reset_q, core_reset_d;
   logic [2:0]             cause_q, cause_d;
   logic [CNT_WIDTH-1:0]   viol_count_q, viol_count_d;
   logic                   busy_q, busy_d;

   logic                   req;
   logic [2:0]             cause_set;
   logic                   new_event;

   always_comb begin
      req          = vrased_reset | casu_reset;
      state_d      = state_q;
      ctr_d        = ctr_q;
      cause_set    = 3'b000;
      new_event    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (req) begin
               state_d   = ST_HOLD;
               ctr_d     = STRETCH_LOAD;
               cause_set = {1'b0, casu_reset, vrased_reset};
               new_event = 1'b1;
            end
         end
         ST_HOLD: begin
            // A request while holding extends the same event: reload, no count.
            if (req) begin
               ctr_d     = STRETCH_LOAD;
               cause_set = {1'b0, casu_reset, vrased_reset};
            end else if (ctr_q == '0) begin
               state_d = ST_WAIT;
               ctr_d   = TIMEOUT_LOAD;
            end else begin
               ctr_d = ctr_q - CTR_ONE;
            end
         end
         ST_WAIT: begin
            if (req) begin
               state_d   = ST_HOLD;
               ctr_d     = STRETCH_LOAD;
               cause_set = {1'b0, casu_reset, vrased_reset};
               new_event = 1'b1;
            end else if (pc == RESET_HANDLER) begin
               state_d = ST_IDLE;
            end else if (ctr_q == '0) begin
               state_d   = ST_HOLD;
               ctr_d     = STRETCH_LOAD;
               cause_set = 3'b100;
               new_event = 1'b1;
            end else begin
               ctr_d = ctr_q - CTR_ONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Set beats clear on the same bit; untouched bits still clear.
      cause_d      = (cause_clr ? 3'b000 : cause_q) | cause_set;
      viol_count_d = (new_event && (viol_count_q != CNT_MAX)) ? viol_count_q + CNT_ONE
                                                               : viol_count_q;
      core_reset_d = (state_d == ST_HOLD);
      busy_d       = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_HOLD;
         ctr_q        <= STRETCH_LOAD;
         core_reset_q <= 1'b1;
         cause_q      <= 3'b000;
         viol_count_q <= '0;
         busy_q       <= 1'b1;
      end else begin
         state_q      <= state_d;
         ctr_q        <= ctr_d;
         core_reset_q <= core_reset_d;
         cause_q      <= cause_d;
         viol_count_q <= viol_count_d;
         busy_q       <= busy_d;
      end
   end

   assign core_reset = core_reset_q;
   assign cause      = cause_q;
   assign viol_count = viol_count_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_hwmod_reset_ctrl.sv
// Bench for hwmod_reset_ctrl: directed scenarios plus random traffic checked
// against a remaining-cycles model of the reset controller.
module tb_hwmod_reset_ctrl;

   localparam int          S  = 16;
   localparam int          T  = 64;
   localparam logic [15:0] RH = 16'h0000;

   logic        clk = 1'b0;
   logic        rst, vr, ca, clr;
   logic [15:0] pc;

   logic        core_a, busy_a, core_s, busy_s;
   logic [2:0]  cause_a, cause_s;
   logic [7:0]  cnt_a;
   logic [1:0]  cnt_s;

   int total = 0;
   int bad   = 0;

   // Model: cycles of core_reset still to come, cycles of handler wait left.
   int          m_hold   = 0;
   int          m_wait   = 0;
   logic [2:0]  m_cause  = 3'b000;
   int          m_events = 0;

   always #5 clk = ~clk;

   hwmod_reset_ctrl #(.STRETCH_CYCLES(S), .TIMEOUT_CYCLES(T), .CNT_WIDTH(8), .RESET_HANDLER(RH)) dut_a (
      .clk(clk), .reset(rst), .vrased_reset(vr), .casu_reset(ca), .pc(pc), .cause_clr(clr),
      .core_reset(core_a), .cause(cause_a), .viol_count(cnt_a), .busy(busy_a));

   hwmod_reset_ctrl #(.STRETCH_CYCLES(S), .TIMEOUT_CYCLES(T), .CNT_WIDTH(2), .RESET_HANDLER(RH)) dut_s (
      .clk(clk), .reset(rst), .vrased_reset(vr), .casu_reset(ca), .pc(pc), .cause_clr(clr),
      .core_reset(core_s), .cause(cause_s), .viol_count(cnt_s), .busy(busy_s));

   function automatic int sat(input int v, input int mx);
      return (v > mx) ? mx : v;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_step();
      logic       req;
      logic [2:0] set;
      req = vr | ca;
      set = {1'b0, ca, vr};
      if (rst) begin
         m_hold   = S;
         m_wait   = 0;
         m_cause  = 3'b000;
         m_events = 0;
         return;
      end
      if (m_hold > 0) begin
         if (req)              m_hold = S;
         else if (m_hold == 1) begin m_hold = 0; m_wait = T; end
         else                  m_hold--;
      end else if (m_wait > 0) begin
         if (req)              begin m_hold = S; m_wait = 0; m_events++; end
         else if (pc == RH)    m_wait = 0;
         else if (m_wait == 1) begin m_wait = 0; m_hold = S; set[2] = 1'b1; m_events++; end
         else                  m_wait--;
      end else if (req) begin
         m_hold = S;
         m_events++;
      end
      m_cause = (clr ? 3'b000 : m_cause) | set;
   endtask

   task automatic check_all();
      chk("m_core",   core_a,  m_hold > 0);
      chk("m_busy",   busy_a,  (m_hold > 0) || (m_wait > 0));
      chk("m_cause",  cause_a, m_cause);
      chk("m_cnt",    cnt_a,   sat(m_events, 255));
      chk("m_core_s", core_s,  m_hold > 0);
      chk("m_cnt_s",  cnt_s,   sat(m_events, 3));
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      check_all();
   endtask

   // Ticks while core_reset stays at lvl; n = ticks that ended at lvl.
   task automatic run_while(input logic lvl, input int limit, output int n);
      n = 0;
      for (int i = 0; i < limit; i++) begin
         tick();
         if (core_a !== lvl) break;
         n++;
      end
   endtask

   // Returns the number of core_reset-high cycles counted from the last reset cycle.
   task automatic power_on(input int rst_cycles, output int highs);
      int h;
      rst = 1'b1; vr = 1'b0; ca = 1'b0; clr = 1'b0;
      repeat (rst_cycles) tick();
      rst = 1'b0;
      run_while(1'b1, 100, h);
      highs = 1 + h;
   endtask

   initial begin
      int h, l;
      int sat_exp[5];
      sat_exp = '{1, 2, 3, 3, 3};
      rst = 1'b1; vr = 1'b0; ca = 1'b0; clr = 1'b0; pc = 16'h0000;

      // Power-on stretch
      power_on(3, h);
      chk("por_width", h, 16);
      chk("por_wait_busy", busy_a, 1'b1);
      tick();
      chk("por_idle_busy", busy_a, 1'b0);
      chk("por_cause", cause_a, 3'b000);
      chk("por_cnt", cnt_a, 8'd0);

      // Single VRASED pulse
      vr = 1'b1; tick(); vr = 1'b0;
      chk("vr_first_high", core_a, 1'b1);
      run_while(1'b1, 100, h);
      chk("vr_width", 1 + h, 16);
      chk("vr_cause", cause_a, 3'b001);
      chk("vr_cnt", cnt_a, 8'd1);
      tick();
      chk("vr_idle", busy_a, 1'b0);

      // Retrigger at HOLD cycle 10
      power_on(1, h);
      tick();
      vr = 1'b1; tick(); vr = 1'b0;
      repeat (9) tick();
      ca = 1'b1; tick(); ca = 1'b0;
      run_while(1'b1, 100, h);
      chk("retrig_width", 11 + h, 26);
      chk("retrig_cause", cause_a, 3'b011);
      chk("retrig_cnt", cnt_a, 8'd1);
      tick();

      // Handler timeout
      pc = 16'hE000;
      power_on(2, h);
      chk("to_por_width", h, 16);
      run_while(1'b0, 200, l);
      chk("to_wait_len", 1 + l, 64);
      run_while(1'b1, 100, h);
      chk("to_hold_width", 1 + h, 16);
      chk("to_cause", cause_a, 3'b100);
      chk("to_cnt", cnt_a, 8'd1);
      pc = 16'h0000;
      tick();
      chk("to_idle", busy_a, 1'b0);

      // Saturation on the 2-bit counter
      power_on(1, h);
      tick();
      for (int k = 0; k < 5; k++) begin
         vr = 1'b1; tick(); vr = 1'b0;
         chk("sat_cnt", cnt_s, sat_exp[k]);
         run_while(1'b1, 100, h);
         tick();
      end

      // Simultaneous requests, clear collision, reset mid-HOLD
      power_on(1, h);
      tick();
      vr = 1'b1; ca = 1'b1; tick(); vr = 1'b0; ca = 1'b0;
      chk("both_cause", cause_a, 3'b011);
      chk("both_cnt", cnt_a, 8'd1);
      run_while(1'b1, 100, h);
      tick();
      clr = 1'b1; vr = 1'b1; tick(); clr = 1'b0; vr = 1'b0;
      chk("clr_cause", cause_a, 3'b001);
      chk("clr_cnt", cnt_a, 8'd2);
      repeat (5) tick();
      rst = 1'b1; tick();
      chk("midrst_core", core_a, 1'b1);
      chk("midrst_cause", cause_a, 3'b000);
      chk("midrst_cnt", cnt_a, 8'd0);
      chk("midrst_busy", busy_a, 1'b1);
      rst = 1'b0;
      run_while(1'b1, 100, h);
      chk("midrst_width", 1 + h, 16);

      // Random traffic against the model
      for (int i = 0; i < 4000; i++) begin
         rst = ($urandom_range(0, 299) == 0);
         vr  = ($urandom_range(0, 39) == 0);
         ca  = ($urandom_range(0, 39) == 0);
         clr = ($urandom_range(0, 19) == 0);
         pc  = ($urandom_range(0, 59) == 0) ? RH : 16'($urandom_range(1, 65535));
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
